// File: rtl/hash_core_arbiter_pkg.sv
// hash_core_arbiter_pkg
//   Shared widths, defaults and state encoding for the hash core arbiter.
//   The same block and digest widths are used by the engines that request
//   hashing, so they can connect to this arbiter directly.
//   Contents:
//     HASH_BLK_W / HASH_DIG_W : message block and digest widths in bits
//     HASH_N_REQ / HASH_CNT_W : default requester count and block counter width
//     state_t                 : arbiter FSM states
//     idxWidth()              : width of an index into n requesters (minimum 1)
package hash_core_arbiter_pkg;

  localparam int HASH_BLK_W = 512;
  localparam int HASH_DIG_W = 512;
  localparam int HASH_N_REQ = 4;
  localparam int HASH_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_CORE = 3'd2,
    WAIT_BLK  = 3'd3,
    RESP      = 3'd4
  } state_t;

  // A single requester still needs a one-bit index so that port widths
  // never collapse to zero.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hash_core_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin priority selector. Returns the first set
//   request at or after the pointer, wrapping around to index 0.
//   Ports:
//     req_i    : request vector, bit i = requester i
//     ptr_i    : index with highest priority this round
//     onehot_o : one-hot of the chosen requester (zero if none)
//     idx_o    : index of the chosen requester (zero if none)
//     any_o    : at least one request is set
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  logic          hiFound;
  logic          loFound;
  logic [IW-1:0] hiIdx;
  logic [IW-1:0] loIdx;

  // Wrapping search: the lowest request at or above the pointer wins.
  // If there is none, the lowest request overall wins, which is the
  // wrap-around case.
  always_comb begin
    hiFound  = 1'b0;
    loFound  = 1'b0;
    hiIdx    = '0;
    loIdx    = '0;
    onehot_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_i[i] && (IW'(i) >= ptr_i) && !hiFound) begin
        hiFound = 1'b1;
        hiIdx   = IW'(i);
      end
      if (req_i[i] && !loFound) begin
        loFound = 1'b1;
        loIdx   = IW'(i);
      end
    end
    any_o = loFound;
    idx_o = hiFound ? hiIdx : loIdx;
    for (int i = 0; i < N_REQ; i++) begin
      onehot_o[i] = loFound && (IW'(i) == idx_o);
    end
  end

endmodule

// File: rtl/hash_core_arbiter.sv
// hash_core_arbiter
//   Shares one hash/compression core between up to N_REQ requesters.
//   Requesters stream message blocks. The winner of a round-robin pick
//   keeps the core until its last block has been compressed. The digest
//   is then returned to that requester, and the core is re-arbitrated.
//   Ports:
//     clk, reset          : clock; asynchronous active-low reset
//     req_valid/last/data : per-requester block handshake (flat data bus)
//     blk_ack             : pulse when the requester's block has been consumed
//     grant               : one-hot current owner (zero when idle)
//     rsp_valid           : pulse to the owner when its digest is ready
//     rsp_digest/blocks   : final digest and block count (held after the pulse)
//     core_start/first    : launch one compression; first resets the chaining value
//     core_din            : block to the core, held until core_done
//     core_done/dout      : core completion pulse and result
//     busy                : arbiter not idle
module hash_core_arbiter
  import hash_core_arbiter_pkg::*;
#(
  parameter int N_REQ = HASH_N_REQ,
  parameter int BLK_W = HASH_BLK_W,
  parameter int DIG_W = HASH_DIG_W,
  parameter int CNT_W = HASH_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_last,
  input  logic [N_REQ*BLK_W-1:0] req_data,
  output logic [N_REQ-1:0]       blk_ack,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [DIG_W-1:0]       rsp_digest,
  output logic [CNT_W-1:0]       rsp_blocks,
  output logic                   core_start,
  output logic                   core_first,
  output logic [BLK_W-1:0]       core_din,
  input  logic                   core_done,
  input  logic [DIG_W-1:0]       core_dout,
  output logic                   busy
);

  localparam int IW = idxWidth(N_REQ);

  state_t           state_q;
  logic [IW-1:0]    owner_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [IW-1:0]    rr_ptr_d;
  logic [CNT_W-1:0] blk_cnt_q;
  logic [CNT_W-1:0] blk_cnt_d;
  logic             last_q;
  logic             first_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] blk_ack_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [DIG_W-1:0] rsp_digest_q;
  logic [CNT_W-1:0] rsp_blocks_q;
  logic             core_start_q;
  logic             core_first_q;
  logic [BLK_W-1:0] core_din_q;
  logic [BLK_W-1:0] owner_data;

  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Next round-robin pointer: the requester after the owner (mod N_REQ).
  // Saturating block count, so a very long message cannot wrap to a small count.
  always_comb begin
    rr_ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
    blk_cnt_d  = (&blk_cnt_q) ? blk_cnt_q : blk_cnt_q + CNT_W'(1);
    owner_data = req_data[int'(owner_q)*BLK_W +: BLK_W];
  end

  // Arbiter FSM. All outputs are registered here. The pulse outputs default
  // low every cycle and are raised for only one cycle. core_done is looked
  // at only in WAIT_CORE, so a stray or abandoned completion has no effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      blk_cnt_q    <= '0;
      last_q       <= 1'b0;
      first_q      <= 1'b0;
      grant_q      <= '0;
      blk_ack_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_digest_q <= '0;
      rsp_blocks_q <= '0;
      core_start_q <= 1'b0;
      core_first_q <= 1'b0;
      core_din_q   <= '0;
    end else begin
      blk_ack_q    <= '0;
      rsp_valid_q  <= '0;
      core_start_q <= 1'b0;
      core_first_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            owner_q   <= pick_idx;
            grant_q   <= pick_onehot;
            blk_cnt_q <= '0;
            first_q   <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          core_start_q <= 1'b1;
          core_first_q <= first_q;
          core_din_q   <= owner_data;
          blk_ack_q    <= grant_q;
          last_q       <= req_last[owner_q];
          blk_cnt_q    <= blk_cnt_d;
          first_q      <= 1'b0;
          state_q      <= WAIT_CORE;
        end
        WAIT_CORE: begin
          if (core_done) begin
            if (last_q) begin
              rsp_digest_q <= core_dout;
              rsp_blocks_q <= blk_cnt_q;
              rsp_valid_q  <= grant_q;
              state_q      <= RESP;
            end else begin
              state_q <= WAIT_BLK;
            end
          end
        end
        WAIT_BLK: begin
          // The owner holds the lock for as long as it takes; other requests wait.
          if (req_valid[owner_q]) begin
            state_q <= ISSUE;
          end
        end
        RESP: begin
          grant_q  <= '0;
          rr_ptr_q <= rr_ptr_d;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant      = grant_q;
  assign blk_ack    = blk_ack_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_digest = rsp_digest_q;
  assign rsp_blocks = rsp_blocks_q;
  assign core_start = core_start_q;
  assign core_first = core_first_q;
  assign core_din   = core_din_q;
  assign busy       = (state_q != IDLE);

endmodule
